fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one fifo write port among NUM_REQ producers.
//  Each producer uses a valid/ready handshake; the arbiter steers one beat per cycle onto the FIFO wr/w_data.
//  Grants are burst-locked: an owner keeps the port until req_last or MAX_BURST beats.
//  Sits between producer blocks (UART/SPI/bus masters) and a shared fifo instance.
// PARAMETERS
//  NUM_REQ    4  number of producers (>=2)
//  DATA_WIDTH 8  beat width; matches fifo DATA_WIDTH
//  MAX_BURST  4  max beats per grant before forced re-arbitration (>=1)
// PORTS
//  clk          in   1                   system clock, rising edge
//  reset        in   1                   synchronous, active-low; sampled on clk rising edge
//  req_valid    in   NUM_REQ             per-producer beat valid
//  req_data     in   NUM_REQ*DATA_WIDTH  packed; producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last     in   NUM_REQ             beat is last of producer's burst
//  req_ready    out  NUM_REQ             beat accepted this cycle when valid&ready
//  fifo_wr      out  1                   write strobe to fifo
//  fifo_w_data  out  DATA_WIDTH          write data to fifo
//  fifo_full    in   1                   fifo full flag
//  grant        out  NUM_REQ             one-hot current owner (registered); 0 when idle
//  busy         out  1                   1 while in BURST
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0; grant=0, busy=0.
//    Outputs while reset==0: req_ready=0, fifo_wr=0, fifo_w_data=0. Mid-burst reset aborts burst; no beat lost/duplicated beyond the cycle.
//  - FSM states IDLE, BURST.
//  - IDLE: if fifo_full=0 and |req_valid, pick = first i with req_valid[i], searching i=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    req_ready[pick]=1 (others 0); beat transfers same cycle (zero latency).
//    If req_last[pick] or MAX_BURST==1: stay IDLE, rr_ptr<=pick+1 mod NUM_REQ.
//    Else: state<=BURST, owner<=pick, beat_cnt<=1, grant<=onehot(pick).
//  - BURST: req_ready[owner]=~fifo_full; all others 0. Other valids ignored.
//    On beat (valid&ready): beat_cnt++. If req_last[owner] or beat_cnt+1==MAX_BURST: state<=IDLE,
//    grant<=0, rr_ptr<=owner+1 mod NUM_REQ, beat_cnt<=0.
//    Owner dropping valid mid-burst: lock held, no beat, no timeout.
//  - fifo_wr = |(req_valid & req_ready); fifo_w_data = accepted producer's slice, else 0.
//  - Never asserts fifo_wr while fifo_full=1; ready deasserts combinationally with fifo_full.
//  - Fifo read concurrent with full is the fifo's concern; arbiter honours only fifo_full as given.
//  - beat_cnt width $clog2(MAX_BURST+1); rr_ptr/owner width $clog2(NUM_REQ); wrap uses explicit compare to NUM_REQ-1 (non-power-of-2 safe).
//  - busy = (state==BURST).
// STRUCTURE
//  - Package fifo_arb_pkg: typedef enum logic {IDLE, BURST} arb_state_t; no other shared constants.
//  - Sub-module rr_pick #(N): combinational rotate-priority encoder (req, ptr) -> (found, idx).
//  - Top: state/rr_ptr/owner/beat_cnt registers, ready/mux logic.
// TESTING
//  1 Reset: reset=0 with all req_valid=1 -> req_ready=0, fifo_wr=0, grant=0; after release first grant to producer 0.
//  2 Fairness: all 4 valid, every req_last=1, fifo_full=0 -> accepts in order 0,1,2,3,0 one per cycle.
//  3 Burst cap: producer 1 streams 10 beats, req_last=0, others valid -> 4 beats from 1, then 2 gets the port.
//  4 Full stall: mid-burst fifo_full=1 for 3 cycles -> req_ready=0, fifo_wr=0, grant unchanged; resumes, no beat lost.
//  5 Owner gap: owner valid=0 for 2 cycles in BURST while producer 3 valid -> producer 3 not served until burst ends.
//  6 Reset mid-burst after 2 beats -> next cycle IDLE, grant=0, rr_ptr=0; producer 0 wins next arbitration.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the fifo write arbiter.
//   arb_state_t : arbiter FSM state (IDLE = free to arbitrate, BURST = port locked to an owner)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer handshakes and the shared fifo write port.
//   req_valid/req_data/req_last : producer side inputs (req_data packed, producer i at
//                                 [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready                   : per-producer accept
//   fifo_wr/fifo_w_data         : write strobe and data to the fifo
//   fifo_full                   : fifo full flag
//   grant/busy                  : registered owner (one-hot) and burst-in-progress status
// Modports: master = producers/fifo environment, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready,
    input  fifo_wr,
    input  fifo_w_data,
    output fifo_full,
    input  grant,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready,
    output fifo_wr,
    output fifo_w_data,
    input  fifo_full,
    output grant,
    output busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   found_o : any request set
//   idx_o   : first set index searching ptr_i, ptr_i+1, ... wrapping at N-1
module rr_pick #(
  parameter int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned     cand;
      logic [IdxW-1:0] cand_idx;
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IdxW'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked write arbiter sharing one fifo write port among NUM_REQ producers.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : producer handshakes, fifo write port, grant/busy status (slave side)
// In IDLE a winner is picked and its first beat transfers in the same cycle. Unless that beat
// is last, the winner then owns the port until req_last or MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic          clk,
  input  logic          reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxBurstC = CntW'(MAX_BURST);
  localparam logic [IdxW-1:0] LastIdxC  = IdxW'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic                 pick_found;
  logic [IdxW-1:0]      pick_idx;
  logic [NUM_REQ-1:0]   ready;
  logic [IdxW-1:0]      sel_idx;
  logic                 wr;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == LastIdxC) ? '0 : idx + IdxW'(1);
  endfunction

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    ready      = '0;
    sel_idx    = owner_q;

    unique case (state_q)
      IDLE: begin
        sel_idx = pick_idx;
        if (!bus.fifo_full && pick_found) begin
          ready[pick_idx] = 1'b1;
          if (bus.req_last[pick_idx] || (MAX_BURST == 1)) begin
            rr_ptr_d = wrap_inc(pick_idx);
          end else begin
            state_d          = BURST;
            owner_d          = pick_idx;
            beat_cnt_d       = CntW'(1);
            grant_d          = '0;
            grant_d[pick_idx] = 1'b1;
          end
        end
      end
      BURST: begin
        // Lock held even when the owner drops valid; other producers wait.
        ready[owner_q] = ~bus.fifo_full;
        if (bus.req_valid[owner_q] && !bus.fifo_full) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (bus.req_last[owner_q] || ((beat_cnt_q + CntW'(1)) == MaxBurstC)) begin
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = wrap_inc(owner_q);
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held.
    if (!reset) begin
      ready = '0;
    end
  end

  assign wr              = |(bus.req_valid & ready);
  assign bus.req_ready   = ready;
  assign bus.fifo_wr     = wr;
  assign bus.fifo_w_data = wr ? bus.req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q == BURST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  fifo_wr_arbiter_if #(.NUM_REQ(NReq), .DATA_WIDTH(Dw)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NReq),
    .DATA_WIDTH (Dw),
    .MAX_BURST  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks happen 2 time units later, well before the
  // next rising edge.
  task automatic set_data(input int unsigned i, input logic [7:0] v);
    bus.req_data[i*Dw +: Dw] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    for (int unsigned i = 0; i < NReq; i++) set_data(i, 8'(8'hA0 + i));
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.fifo_full = 1'b0;
    for (int unsigned i = 0; i < NReq; i++) set_data(i, 8'(8'hA0 + i));
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
      end
      checks++;
      if (bus.fifo_wr !== 1'b0 || bus.fifo_w_data !== 8'h00) begin
        errors++; $display("FAIL reset_wr: got wr=%b data=%h want 0/00", bus.fifo_wr, bus.fifo_w_data);
      end
      @(negedge clk);
    end
    #2;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_grant: got %b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.fifo_wr !== 1'b1 || bus.fifo_w_data !== 8'hA0) begin
      errors++; $display("FAIL reset_first: got ready=%b wr=%b data=%h want 0001/1/a0",
                         bus.req_ready, bus.fifo_wr, bus.fifo_w_data);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ready;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      #2;
      checks++;
      if (bus.req_ready !== exp_ready || bus.fifo_wr !== 1'b1 ||
          bus.fifo_w_data !== 8'(8'hA0 + (k % 4)) || bus.busy !== 1'b0) begin
        errors++; $display("FAIL fair_%0d: got ready=%b wr=%b data=%h busy=%b want %b/1/%h/0",
                           k, bus.req_ready, bus.fifo_wr, bus.fifo_w_data, bus.busy,
                           exp_ready, 8'(8'hA0 + (k % 4)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    // Move rr_ptr to 1 with a single last beat from producer 0.
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      set_data(1, 8'(8'h10 + b));
      #2;
      checks++;
      if (bus.req_ready !== 4'b0010 || bus.fifo_wr !== 1'b1 || bus.fifo_w_data !== 8'(8'h10 + b)) begin
        errors++; $display("FAIL cap_beat%0d: got ready=%b wr=%b data=%h want 0010/1/%h",
                           b, bus.req_ready, bus.fifo_wr, bus.fifo_w_data, 8'(8'h10 + b));
      end
      checks++;
      if (bus.grant !== ((b == 0) ? 4'b0000 : 4'b0010) || bus.busy !== (b != 0)) begin
        errors++; $display("FAIL cap_grant%0d: got grant=%b busy=%b", b, bus.grant, bus.busy);
      end
      @(negedge clk);
    end
    set_data(1, 8'h14);
    #2;
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.fifo_w_data !== 8'hA2 || bus.grant !== 4'b0000) begin
      errors++; $display("FAIL cap_handoff: got ready=%b data=%h grant=%b want 0100/a2/0000",
                         bus.req_ready, bus.fifo_w_data, bus.grant);
    end
  endtask

  task automatic test_full_stall();
    int unsigned got;
    logic [7:0]  seen [4];
    do_reset();
    got           = 0;
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0000;
    for (int c = 0; c < 9 && got < 4; c++) begin
      set_data(0, 8'(8'h50 + got));
      bus.fifo_full = (c >= 2 && c < 5);
      #2;
      if (bus.fifo_full) begin
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.fifo_wr !== 1'b0 ||
            bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL stall_%0d: got ready=%b wr=%b grant=%b busy=%b want 0000/0/0001/1",
                             c, bus.req_ready, bus.fifo_wr, bus.grant, bus.busy);
        end
      end
      if (bus.fifo_wr === 1'b1) begin
        seen[got] = bus.fifo_w_data;
        got++;
      end
      @(negedge clk);
    end
    bus.fifo_full = 1'b0;
    checks++;
    if (got !== 4 || seen[0] !== 8'h50 || seen[1] !== 8'h51 || seen[2] !== 8'h52 ||
        seen[3] !== 8'h53) begin
      errors++; $display("FAIL stall_beats: got %0d beats %h %h %h %h want 4 beats 50 51 52 53",
                         got, seen[0], seen[1], seen[2], seen[3]);
    end
    bus.req_valid = 4'b0000;
    #2;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL stall_end: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_owner_gap();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0000;
    @(negedge clk);
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (bus.req_ready !== 4'b0001 || bus.fifo_wr !== 1'b0 || bus.grant !== 4'b0001) begin
        errors++; $display("FAIL gap_%0d: got ready=%b wr=%b grant=%b want 0001/0/0001",
                           c, bus.req_ready, bus.fifo_wr, bus.grant);
      end
      @(negedge clk);
    end
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b0001;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.fifo_wr !== 1'b1 || bus.fifo_w_data !== 8'hA0) begin
      errors++; $display("FAIL gap_resume: got ready=%b wr=%b data=%h want 0001/1/a0",
                         bus.req_ready, bus.fifo_wr, bus.fifo_w_data);
    end
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #2;
    checks++;
    if (bus.req_ready !== 4'b1000 || bus.fifo_w_data !== 8'hA3 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL gap_p3: got ready=%b data=%h busy=%b want 1000/a3/0",
                         bus.req_ready, bus.fifo_w_data, bus.busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got grant=%b busy=%b want 0100/1", bus.grant, bus.busy);
    end
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 4'b1111;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.fifo_wr !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got ready=%b wr=%b want 0000/0", bus.req_ready, bus.fifo_wr);
    end
    @(negedge clk);
    #2;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_idle: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    reset        = 1'b1;
    bus.req_last = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.fifo_w_data !== 8'hA0) begin
      errors++; $display("FAIL mid_p0: got ready=%b data=%h want 0001/a0", bus.req_ready,
                         bus.fifo_w_data);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_fairness();
    test_burst_cap();
    test_full_stall();
    test_owner_gap();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
